// File: rtl/wf_pkg.sv
// Shared waterfall definitions: geometry defaults and writer state encoding.
// Reused by the video, FFT and row-scheduler blocks.
package wf_pkg;

    localparam int WF_COLS = 320;
    localparam int WF_ROWS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } wf_state_e;

endpackage

// File: rtl/wf_row_scheduler_if.sv
// Video port, sample stream and RAM bus of the waterfall row scheduler.
// The slave modport is the scheduler's view; master is its environment.
interface wf_row_scheduler_if #(
    parameter int ADDR_W = 15,
    parameter int ROW_W  = 6
);
    logic              frame_start;
    logic              vid_req;
    logic [8:0]        vid_x;
    logic [7:0]        vid_y;
    logic [7:0]        vid_data;
    logic              vid_valid;
    logic              wr_valid;
    logic [7:0]        wr_data;
    logic              wr_last;
    logic              wr_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic [ROW_W-1:0]  top_row;

    modport master (
        output frame_start, vid_req, vid_x, vid_y,
        output wr_valid, wr_data, wr_last, mem_rdata,
        input  vid_data, vid_valid, wr_ready,
        input  mem_addr, mem_we, mem_wdata, top_row
    );

    modport slave (
        input  frame_start, vid_req, vid_x, vid_y,
        input  wr_valid, wr_data, wr_last, mem_rdata,
        output vid_data, vid_valid, wr_ready,
        output mem_addr, mem_we, mem_wdata, top_row
    );
endinterface

// File: rtl/wf_addr_gen.sv
// Ring-buffer address: ((base + offs) mod ROWS) * COLS + col.
// Both operands are below ROWS, so one conditional subtract wraps the sum.
module wf_addr_gen #(
    parameter int COLS   = 320,
    parameter int ROWS   = 64,
    parameter int ADDR_W = 15,
    parameter int ROW_W  = 6,
    parameter int COL_W  = 9
) (
    input  logic [ROW_W-1:0]  base,
    input  logic [ROW_W-1:0]  offs,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr
);
    logic [ROW_W:0]   sum;
    logic [ROW_W-1:0] row;

    always_comb begin
        sum = {1'b0, base} + {1'b0, offs};
        if (sum >= (ROW_W+1)'(ROWS)) begin
            row = ROW_W'(sum - (ROW_W+1)'(ROWS));
        end else begin
            row = sum[ROW_W-1:0];
        end
        addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    end
endmodule

// File: rtl/wf_row_scheduler.sv
// Waterfall row scheduler: fills one ring-buffer row per frame, commits it
// at frame start, and arbitrates the single-port RAM with video reads first.
module wf_row_scheduler
    import wf_pkg::*;
#(
    parameter int COLS    = WF_COLS,
    parameter int ROWS    = WF_ROWS,
    parameter int Y_SHIFT = 2,
    parameter int ADDR_W  = 15
) (
    input logic clk,
    input logic resetn,
    wf_row_scheduler_if.slave bus
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = 9;

    wf_state_e        state_q, state_d;
    logic [ROW_W-1:0] top_row_q, top_row_d;
    logic [ROW_W-1:0] wrow_q, wrow_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             rd_q, rd_d;
    logic             oor_q, oor_d;
    logic             vid_valid_q, vid_valid_d;
    logic [7:0]       vid_data_q, vid_data_d;

    logic [7:0]        vrow;
    logic              vid_oor;
    logic              vid_rd;
    logic              accept;
    logic [ROW_W-1:0]  ag_base, ag_offs;
    logic [COL_W-1:0]  ag_col;
    logic [ADDR_W-1:0] ag_addr;

    always_comb begin
        vrow    = bus.vid_y >> Y_SHIFT;
        vid_oor = (int'(vrow) >= ROWS) || (int'(bus.vid_x) >= COLS);
        vid_rd  = resetn && bus.vid_req && !vid_oor;
        bus.wr_ready = resetn && (state_q == FILL) && !bus.vid_req;
        accept  = bus.wr_valid && bus.wr_ready;
    end

    // One address generator, steered to the video read when it is requested.
    always_comb begin
        ag_base = wrow_q;
        ag_offs = '0;
        ag_col  = col_q;
        if (bus.vid_req) begin
            ag_base = top_row_q;
            ag_offs = vrow[ROW_W-1:0];
            ag_col  = bus.vid_x;
        end
    end

    wf_addr_gen #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_addr_gen (
        .base (ag_base),
        .offs (ag_offs),
        .col  (ag_col),
        .addr (ag_addr)
    );

    always_comb begin
        bus.mem_we    = accept;
        bus.mem_addr  = (vid_rd || accept) ? ag_addr : '0;
        bus.mem_wdata = accept ? bus.wr_data : 8'h00;
    end

    always_comb begin
        state_d   = state_q;
        top_row_d = top_row_q;
        wrow_d    = wrow_q;
        col_d     = col_q;
        unique case (state_q)
            IDLE: begin
                state_d = FILL;
                col_d   = '0;
                if (top_row_q == '0) begin
                    wrow_d = ROW_W'(ROWS - 1);
                end else begin
                    wrow_d = top_row_q - ROW_W'(1);
                end
            end
            FILL: begin
                if (accept) begin
                    col_d = col_q + COL_W'(1);
                    if (bus.wr_last || col_q == COL_W'(COLS - 1)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Commit only at a frame boundary so the display never tears.
                if (bus.frame_start) begin
                    top_row_d = wrow_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_d        = resetn && bus.vid_req;
        oor_d       = vid_oor;
        vid_valid_d = rd_q;
        vid_data_d  = oor_q ? 8'h00 : bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            top_row_q   <= '0;
            wrow_q      <= '0;
            col_q       <= '0;
            rd_q        <= 1'b0;
            oor_q       <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            top_row_q   <= top_row_d;
            wrow_q      <= wrow_d;
            col_q       <= col_d;
            rd_q        <= rd_d;
            oor_q       <= oor_d;
            vid_valid_q <= vid_valid_d;
            vid_data_q  <= vid_data_d;
        end
    end

    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_data  = vid_data_q;
    assign bus.top_row   = top_row_q;
endmodule

// File: tb/tb_wf_row_scheduler.sv
// Directed bench for wf_row_scheduler with a 1-cycle-latency RAM model.
// Expected values are hand-computed for COLS=320, ROWS=64, Y_SHIFT=2.
module tb_wf_row_scheduler;

    logic clk = 1'b0;
    logic resetn;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [5:0] exp_top;

    always #5 clk = ~clk;

    wf_row_scheduler_if #(.ADDR_W(15), .ROW_W(6)) bus ();

    wf_row_scheduler #(
        .COLS    (320),
        .ROWS    (64),
        .Y_SHIFT (2),
        .ADDR_W  (15)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [7:0] ram [0:20479] = '{default: 8'hFF};
    logic [7:0] rdata_q = 8'h00;

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        rdata_q <= ram[bus.mem_addr];
    end

    assign bus.mem_rdata = rdata_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn          = 1'b0;
        bus.frame_start = 1'b0;
        bus.vid_req     = 1'b0;
        bus.vid_x       = 9'd0;
        bus.vid_y       = 8'd0;
        bus.wr_valid    = 1'b1;
        bus.wr_data     = 8'h77;
        bus.wr_last     = 1'b0;
        repeat (3) tick();
        check("rst_top", 32'(bus.top_row), 0);
        check("rst_vvalid", 32'(bus.vid_valid), 0);
        check("rst_vdata", 32'(bus.vid_data), 0);
        check("rst_we", 32'(bus.mem_we), 0);
        check("rst_addr", 32'(bus.mem_addr), 0);
        check("rst_wdata", 32'(bus.mem_wdata), 0);
        check("rst_ready", 32'(bus.wr_ready), 0);

        // Single full row into row 63.
        resetn = 1'b1;
        tick();
        for (int i = 0; i < 320; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(i) ^ 8'hA5;
            bus.wr_last  = (i == 319);
            #1;
            check("row_ready", 32'(bus.wr_ready), 1);
            check("row_we", 32'(bus.mem_we), 1);
            check("row_addr", 32'(bus.mem_addr), 32'(20160 + i));
            check("row_wdata", 32'(bus.mem_wdata), 32'(8'(i) ^ 8'hA5));
            tick();
        end
        bus.wr_last = 1'b0;
        #1;
        check("hold_ready", 32'(bus.wr_ready), 0);
        check("hold_we", 32'(bus.mem_we), 0);
        repeat (3) tick();
        check("hold_top", 32'(bus.top_row), 0);
        bus.wr_valid    = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("commit_top", 32'(bus.top_row), 63);

        // Read latency: row 63 col 5 holds 0x05^0xA5.
        bus.vid_req = 1'b1;
        bus.vid_x   = 9'd5;
        bus.vid_y   = 8'd0;
        #1;
        check("rd_addr", 32'(bus.mem_addr), 20165);
        check("rd_we", 32'(bus.mem_we), 0);
        tick();
        bus.vid_req = 1'b0;
        check("rd_valid_c1", 32'(bus.vid_valid), 0);
        tick();
        check("rd_valid_c2", 32'(bus.vid_valid), 1);
        check("rd_data", 32'(bus.vid_data), 32'h A0);
        tick();
        check("rd_valid_c3", 32'(bus.vid_valid), 0);

        // Collision: read wins, beat lands on the next cycle at col 0 of row 62.
        bus.vid_req  = 1'b1;
        bus.vid_x    = 9'd5;
        bus.vid_y    = 8'd0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h3C;
        #1;
        check("col_ready", 32'(bus.wr_ready), 0);
        check("col_we", 32'(bus.mem_we), 0);
        check("col_rdaddr", 32'(bus.mem_addr), 20165);
        tick();
        bus.vid_req = 1'b0;
        #1;
        check("col_ready2", 32'(bus.wr_ready), 1);
        check("col_we2", 32'(bus.mem_we), 1);
        check("col_wraddr", 32'(bus.mem_addr), 19840);
        check("col_wdata", 32'(bus.mem_wdata), 32'h3C);
        tick();
        bus.wr_data     = 8'h3D;
        bus.wr_last     = 1'b1;
        bus.frame_start = 1'b1;
        #1;
        check("col_wraddr2", 32'(bus.mem_addr), 19841);
        check("col_vvalid", 32'(bus.vid_valid), 1);
        check("col_vdata", 32'(bus.vid_data), 32'hA0);
        tick();
        bus.wr_valid    = 1'b0;
        bus.wr_last     = 1'b0;
        bus.frame_start = 1'b0;
        check("fill_fs_top", 32'(bus.top_row), 63);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("commit2_top", 32'(bus.top_row), 62);

        // Back-to-back reads, including the two range boundaries.
        bus.vid_req = 1'b1;
        bus.vid_x   = 9'd1;
        bus.vid_y   = 8'd0;
        #1;
        check("rb_addr0", 32'(bus.mem_addr), 19841);
        tick();
        bus.vid_x = 9'd5;
        bus.vid_y = 8'd4;
        #1;
        check("rb_addr1", 32'(bus.mem_addr), 20165);
        tick();
        bus.vid_x = 9'd0;
        bus.vid_y = 8'd255;
        #1;
        check("rb_addr_y255", 32'(bus.mem_addr), 19520);
        check("rb_data0", 32'(bus.vid_data), 32'h3D);
        tick();
        bus.vid_x    = 9'd330;
        bus.wr_valid = 1'b1;
        #1;
        check("oor_we", 32'(bus.mem_we), 0);
        check("oor_ready", 32'(bus.wr_ready), 0);
        check("rb_data1", 32'(bus.vid_data), 32'hA0);
        tick();
        bus.vid_req  = 1'b0;
        bus.wr_valid = 1'b0;
        check("rb_valid2", 32'(bus.vid_valid), 1);
        check("rb_data2", 32'(bus.vid_data), 32'hFF);
        tick();
        check("oor_valid", 32'(bus.vid_valid), 1);
        check("oor_data", 32'(bus.vid_data), 0);
        tick();
        check("rb_valid_end", 32'(bus.vid_valid), 0);

        // Reset after 100 beats with a read in flight.
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h11;
        repeat (100) tick();
        bus.vid_req = 1'b1;
        bus.vid_x   = 9'd0;
        bus.vid_y   = 8'd0;
        tick();
        bus.vid_req = 1'b0;
        resetn      = 1'b0;
        tick();
        check("rst2_vvalid", 32'(bus.vid_valid), 0);
        check("rst2_vdata", 32'(bus.vid_data), 0);
        check("rst2_top", 32'(bus.top_row), 0);
        check("rst2_we", 32'(bus.mem_we), 0);
        check("rst2_ready", 32'(bus.wr_ready), 0);
        check("rst2_addr", 32'(bus.mem_addr), 0);
        check("rst2_wdata", 32'(bus.mem_wdata), 0);
        bus.wr_valid = 1'b0;
        tick();
        resetn = 1'b1;

        // 65 one-beat rows: top_row walks 63..0 and wraps back to 63.
        exp_top = 6'd0;
        for (int k = 0; k < 65; k++) begin
            tick();
            exp_top      = exp_top - 6'd1;
            bus.wr_valid = 1'b1;
            bus.wr_last  = 1'b1;
            bus.wr_data  = 8'(k);
            #1;
            check("wrap_addr", 32'(bus.mem_addr), 32'(int'(exp_top) * 320));
            tick();
            bus.wr_valid    = 1'b0;
            bus.wr_last     = 1'b0;
            bus.frame_start = 1'b1;
            tick();
            bus.frame_start = 1'b0;
            check("wrap_top", 32'(bus.top_row), 32'(exp_top));
        end

        // vrow 1 at top_row 63 lands on row 0.
        bus.vid_req = 1'b1;
        bus.vid_x   = 9'd7;
        bus.vid_y   = 8'd4;
        #1;
        check("wrap_rdaddr7", 32'(bus.mem_addr), 7);
        tick();
        bus.vid_x = 9'd0;
        tick();
        bus.vid_req = 1'b0;
        check("wrap_valid7", 32'(bus.vid_valid), 1);
        check("wrap_data7", 32'(bus.vid_data), 32'hFF);
        tick();
        check("wrap_valid0", 32'(bus.vid_valid), 1);
        check("wrap_data0", 32'(bus.vid_data), 32'h3F);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wf_row_scheduler.md
WF_ROW_SCHEDULER -- requirements
Module: wf_row_scheduler

Interface
REQ-001 SHALL have parameters: COLS, default 320, pixels per waterfall row; ROWS, default 64, rows in ring buffer; Y_SHIFT, default 2, display lines per row as a power of two; ADDR_W, default 15, memory address width.
REQ-002 SHALL have port clk, in, 1, system clock.
REQ-003 SHALL have port resetn, in, 1, synchronous active-low reset.
REQ-004 SHALL have port frame_start, in, 1, one-cycle pulse at start of vertical blanking.
REQ-005 SHALL have port vid_req, in, 1, video pixel read request (single-cycle pulse).
REQ-006 SHALL have ports vid_x, in, 9, pixel column, and vid_y, in, 8, pixel line.
REQ-007 SHALL have ports vid_data, out, 8, pixel sample, and vid_valid, out, 1, vid_data qualifier.
REQ-008 SHALL have ports wr_valid, in, 1; wr_data, in, 8; wr_last, in, 1, end of row; wr_ready, out, 1: a valid/ready sample stream.
REQ-009 SHALL have ports mem_addr, out, ADDR_W; mem_we, out, 1; mem_wdata, out, 8; mem_rdata, in, 8: a single-port RAM with 1-cycle read latency.
REQ-010 SHALL have port top_row, out, log2(ROWS), the ring index of the newest row.

Function
REQ-011 SHALL store row r, column c at address r*COLS+c, with r<ROWS and c<COLS.
REQ-012 SHALL grant the RAM to video when vid_req=1, and otherwise to the writer when a write beat is accepted; only one access per cycle.
REQ-013 SHALL set wr_ready = (state==FILL) && !vid_req; a beat is accepted when wr_valid && wr_ready.
REQ-014 SHALL compute vrow = vid_y>>Y_SHIFT and the read address ((top_row+vrow) mod ROWS)*COLS+vid_x.
REQ-015 SHALL assert vid_valid exactly 2 cycles after vid_req, with vid_data = registered mem_rdata.
REQ-016 SHALL return vid_data=0 with vid_valid=1 when vrow>=ROWS or vid_x>=COLS, with no RAM read.
REQ-017 SHALL have states IDLE, FILL and HOLD.
REQ-018 SHALL move IDLE->FILL on the next cycle, with write row wrow=(top_row-1) mod ROWS and column counter col=0.
REQ-019 SHALL, on FILL with an accepted beat, drive mem_we=1, mem_addr=wrow*COLS+col, mem_wdata=wr_data, then increment col.
REQ-020 SHALL move FILL->HOLD on an accepted beat with wr_last=1 or col==COLS-1; unwritten columns keep stale contents.
REQ-021 SHALL hold wr_ready=0 in HOLD.
REQ-022 SHALL, in HOLD on frame_start, set top_row<=wrow and go to IDLE; the row commits only at a frame boundary, so the display never tears.
REQ-023 SHALL ignore frame_start in IDLE and FILL; top_row is unchanged.
REQ-024 SHALL treat wr_last after col wrap as a new-row beat only if in FILL.
REQ-025 SHALL, when vid_req coincides with a write beat, service the video read; the write beat is stalled (not lost) because wr_ready=0.
REQ-026 SHALL wrap top_row mod ROWS: 0-1 gives ROWS-1.

Reset
REQ-027 SHALL, while resetn=0, reset: state=IDLE, top_row=0, col=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_ready=0, vid_valid=0, vid_data=0, and clear the read pipeline.
REQ-028 SHALL, on reset mid-FILL, discard the partial row without committing it; in-flight vid_valid is dropped.

Structure
REQ-029 SHALL keep the state encoding and the COLS/ROWS defaults in a shared package wf_pkg, reused by the video and FFT blocks.
REQ-030 SHALL use one sub-module, wf_addr_gen (row*COLS+col plus modulo-ROWS add), shared by the read and write paths; the rest stays flat.

Verification
REQ-031 SHALL cover single row: 320 beats with wr_valid held and wr_last on beat 320 -> 320 mem_we pulses at addresses 63*320+0..319; HOLD; top_row stays 0 until frame_start, then becomes 63.
REQ-032 SHALL cover read latency: after commit, vid_req at vid_x=5, vid_y=0 -> mem_addr=20165, then vid_valid 2 cycles later with the stored byte.
REQ-033 SHALL cover collision: vid_req and wr_valid on the same cycle -> wr_ready=0 and the read is issued; the beat is written the next cycle at the same col with no sample loss.
REQ-034 SHALL cover out of range: vid_y=255 (vrow 63 ok) and vid_x=330 -> vid_valid after 2 cycles, vid_data=0, and no RAM access.
REQ-035 SHALL cover wrap: 65 committed rows -> top_row sequence 63,62..0,63, with correct read address wraparound for vrow=1 at top_row=63 (row 0).
REQ-036 SHALL cover reset mid-row: resetn low after 100 beats -> all outputs at reset values, top_row=0, and the next row restarts at col 0.
